// File: rtl/jtag_tap_target.sv
// jtag_tap_target
// Clock-domain JTAG TAP responder. It oversamples tck/tms/tdi with clk and runs
// the 16-state IEEE 1149.1 TAP controller. It provides the IR, BYPASS, IDCODE and
// USER data registers, and drives tdo. The USER register trades bytes with local
// logic through a capture/update handshake.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   tck, tms, tdi     JTAG pins (asynchronous to clk)
//   tdo               JTAG serial out, updated on tck fall
//   cap_data/valid    byte offered to USER at Capture-DR
//   cap_rd            1-clk pulse when cap_data is consumed
//   upd_data/valid    byte written at Update-DR, 1-clk valid pulse
//   ir_value          active instruction
//   tap_state         current TAP state code
module jtag_tap_target #(
  parameter int unsigned          IR_WIDTH     = 10,
  parameter int unsigned          DR_WIDTH     = 8,
  parameter logic [31:0]          IDCODE_VAL   = 32'h1234_5A5B,
  parameter logic [IR_WIDTH-1:0]  IDCODE_INSTR = 10'h001,
  parameter logic [IR_WIDTH-1:0]  USER_INSTR   = 10'h002
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  input  logic [DR_WIDTH-1:0] cap_data,
  input  logic                cap_valid,
  output logic                cap_rd,
  output logic [DR_WIDTH-1:0] upd_data,
  output logic                upd_valid,
  output logic [IR_WIDTH-1:0] ir_value,
  output logic [3:0]          tap_state
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PA_DR  = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PA_IR  = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_state_e;

  logic                tck_meta_q, tck_sync_q, tck_prev_q;
  logic                tms_meta_q, tms_sync_q;
  logic                tdi_meta_q, tdi_sync_q;
  logic [1:0]          fill_q;
  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_value_q;
  logic [31:0]         id_shift_q;
  logic                bypass_q;
  logic [DR_WIDTH-1:0] user_shift_q, upd_data_q;
  logic                tdo_q, cap_rd_q, upd_valid_q;

  logic tck_rise_s, tck_fall_s;
  logic sel_idcode_s, sel_user_s, dr_lsb_s;

  // Edges are masked until the synchronizer and history hold real pin samples,
  // so a tck already high when reset releases is not mistaken for a rise.
  assign tck_rise_s   = (fill_q == 2'd3) &&  tck_sync_q && !tck_prev_q;
  assign tck_fall_s   = (fill_q == 2'd3) && !tck_sync_q &&  tck_prev_q;
  assign sel_idcode_s = (ir_value_q == IDCODE_INSTR);
  assign sel_user_s   = (ir_value_q == USER_INSTR);

  // LSB of whichever data register the active instruction selects.
  always_comb begin
    dr_lsb_s = bypass_q;
    if (sel_idcode_s) begin
      dr_lsb_s = id_shift_q[0];
    end else if (sel_user_s) begin
      dr_lsb_s = user_shift_q[0];
    end else begin
      dr_lsb_s = bypass_q;
    end
  end

  // TAP next-state table, indexed by the synchronized tms.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = tms_sync_q ? TLR    : RTI;
      RTI:     state_d = tms_sync_q ? SEL_DR : RTI;
      SEL_DR:  state_d = tms_sync_q ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = tms_sync_q ? EX1_DR : SH_DR;
      SH_DR:   state_d = tms_sync_q ? EX1_DR : SH_DR;
      EX1_DR:  state_d = tms_sync_q ? UPD_DR : PA_DR;
      PA_DR:   state_d = tms_sync_q ? EX2_DR : PA_DR;
      EX2_DR:  state_d = tms_sync_q ? UPD_DR : SH_DR;
      UPD_DR:  state_d = tms_sync_q ? SEL_DR : RTI;
      SEL_IR:  state_d = tms_sync_q ? TLR    : CAP_IR;
      CAP_IR:  state_d = tms_sync_q ? EX1_IR : SH_IR;
      SH_IR:   state_d = tms_sync_q ? EX1_IR : SH_IR;
      EX1_IR:  state_d = tms_sync_q ? UPD_IR : PA_IR;
      PA_IR:   state_d = tms_sync_q ? EX2_IR : PA_IR;
      EX2_IR:  state_d = tms_sync_q ? UPD_IR : SH_IR;
      UPD_IR:  state_d = tms_sync_q ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Synchronizers, TAP state, scan registers and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_meta_q   <= 1'b0;
      tck_sync_q   <= 1'b0;
      tck_prev_q   <= 1'b0;
      tms_meta_q   <= 1'b0;
      tms_sync_q   <= 1'b0;
      tdi_meta_q   <= 1'b0;
      tdi_sync_q   <= 1'b0;
      fill_q       <= 2'd0;
      state_q      <= TLR;
      ir_shift_q   <= {IR_WIDTH{1'b0}};
      ir_value_q   <= IDCODE_INSTR;
      id_shift_q   <= 32'h0000_0000;
      bypass_q     <= 1'b0;
      user_shift_q <= {DR_WIDTH{1'b0}};
      upd_data_q   <= {DR_WIDTH{1'b0}};
      tdo_q        <= 1'b0;
      cap_rd_q     <= 1'b0;
      upd_valid_q  <= 1'b0;
    end else begin
      tck_meta_q  <= tck;
      tck_sync_q  <= tck_meta_q;
      tck_prev_q  <= tck_sync_q;
      tms_meta_q  <= tms;
      tms_sync_q  <= tms_meta_q;
      tdi_meta_q  <= tdi;
      tdi_sync_q  <= tdi_meta_q;
      if (fill_q != 2'd3) begin
        fill_q <= fill_q + 2'd1;
      end
      cap_rd_q    <= 1'b0;
      upd_valid_q <= 1'b0;

      // Rise: capture/shift in the pre-transition state, then advance.
      if (tck_rise_s) begin
        state_q <= state_d;
        case (state_q)
          CAP_IR: ir_shift_q <= {{(IR_WIDTH-1){1'b0}}, 1'b1};
          SH_IR:  ir_shift_q <= {tdi_sync_q, ir_shift_q[IR_WIDTH-1:1]};
          CAP_DR: begin
            if (sel_idcode_s) begin
              id_shift_q <= IDCODE_VAL;
            end else if (sel_user_s) begin
              user_shift_q <= cap_valid ? cap_data : {DR_WIDTH{1'b0}};
              cap_rd_q     <= cap_valid;
            end else begin
              bypass_q <= 1'b0;
            end
          end
          SH_DR: begin
            if (sel_idcode_s) begin
              id_shift_q <= {tdi_sync_q, id_shift_q[31:1]};
            end else if (sel_user_s) begin
              user_shift_q <= {tdi_sync_q, user_shift_q[DR_WIDTH-1:1]};
            end else begin
              bypass_q <= tdi_sync_q;
            end
          end
          default: ;
        endcase
      end

      // Fall: updates and tdo launch, so tdo is settled before the next rise.
      if (tck_fall_s) begin
        case (state_q)
          UPD_IR: begin
            ir_value_q <= ir_shift_q;
            tdo_q      <= 1'b0;
          end
          UPD_DR: begin
            if (sel_user_s) begin
              upd_data_q  <= user_shift_q;
              upd_valid_q <= 1'b1;
            end
            tdo_q <= 1'b0;
          end
          SH_IR:   tdo_q <= ir_shift_q[0];
          SH_DR:   tdo_q <= dr_lsb_s;
          default: tdo_q <= 1'b0;
        endcase
      end

      if (state_q == TLR) begin
        ir_value_q <= IDCODE_INSTR;
      end
    end
  end

  assign tdo       = tdo_q;
  assign cap_rd    = cap_rd_q;
  assign upd_data  = upd_data_q;
  assign upd_valid = upd_valid_q;
  assign ir_value  = ir_value_q;
  assign tap_state = state_q;

endmodule

// File: tb/tb_jtag_tap_target.sv
// Directed testbench for jtag_tap_target. tck runs with 5-clk high/low phases;
// tdo is sampled late in each low phase, just before the rise that shifts it.
module tb_jtag_tap_target;

  logic       clk = 1'b0;
  logic       rst, tck, tms, tdi, tdo;
  logic [7:0] cap_data, upd_data;
  logic       cap_valid, cap_rd, upd_valid;
  logic [9:0] ir_value;
  logic [3:0] tap_state;

  int checks   = 0;
  int failures = 0;
  int cap_pulses = 0;
  int upd_pulses = 0;

  jtag_tap_target dut (
    .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
    .cap_data(cap_data), .cap_valid(cap_valid), .cap_rd(cap_rd),
    .upd_data(upd_data), .upd_valid(upd_valid),
    .ir_value(ir_value), .tap_state(tap_state)
  );

  always #5 clk = ~clk;

  // Count every clk during which a pulse output is high.
  always @(posedge clk) begin
    if (cap_rd === 1'b1) cap_pulses <= cap_pulses + 1;
    if (upd_valid === 1'b1) upd_pulses <= upd_pulses + 1;
  end

  // One full tck period: set tms/tdi, low phase, sample tdo, rise, high phase, fall.
  task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
    tms = tms_v;
    tdi = tdi_v;
    repeat (5) @(negedge clk);
    tdo_v = tdo;
    tck = 1'b1;
    repeat (5) @(negedge clk);
    tck = 1'b0;
  endtask

  // IR or DR scan from RTI back to RTI; dout collects tdo LSB-first.
  task automatic scan(input bit is_ir, input int n, input logic [31:0] din,
                      output logic [31:0] dout);
    logic t;
    dout = 32'h0;
    tck_cycle(1'b1, 1'b0, t);
    if (is_ir) tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], t);
      dout[i] = t;
    end
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
  endtask

  task automatic test_reset();
    rst = 1'b1; tck = 1'b0; tms = 1'b0; tdi = 1'b0;
    cap_data = 8'h00; cap_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks += 6;
    if (tap_state !== 4'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", tap_state); end
    if (ir_value !== 10'h001) begin failures++; $display("FAIL reset_ir: got %h expected 001", ir_value); end
    if (tdo !== 1'b0) begin failures++; $display("FAIL reset_tdo: got %b expected 0", tdo); end
    if (cap_rd !== 1'b0) begin failures++; $display("FAIL reset_cap_rd: got %b expected 0", cap_rd); end
    if (upd_valid !== 1'b0) begin failures++; $display("FAIL reset_upd_valid: got %b expected 0", upd_valid); end
    if (upd_data !== 8'h00) begin failures++; $display("FAIL reset_upd_data: got %h expected 00", upd_data); end
  endtask

  task automatic test_idcode();
    logic t;
    logic [31:0] d;
    tck_cycle(1'b0, 1'b0, t);
    scan(1'b0, 32, 32'h0, d);
    checks += 2;
    if (d !== 32'h1234_5A5B) begin failures++; $display("FAIL idcode: got %h expected 12345a5b", d); end
    if (tap_state !== 4'd1) begin failures++; $display("FAIL idcode_end_state: got %0d expected 1", tap_state); end
  endtask

  task automatic test_tlr_return();
    logic t;
    logic [31:0] d;
    scan(1'b1, 10, 32'h002, d);
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    checks += 4;
    if (ir_value !== 10'h002) begin failures++; $display("FAIL tlr_pre_ir: got %h expected 002", ir_value); end
    if (tap_state !== 4'd4) begin failures++; $display("FAIL tlr_pre_state: got %0d expected 4", tap_state); end
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t);
    if (tap_state !== 4'd0) begin failures++; $display("FAIL tlr_state: got %0d expected 0", tap_state); end
    if (ir_value !== 10'h001) begin failures++; $display("FAIL tlr_ir: got %h expected 001", ir_value); end
    tck_cycle(1'b0, 1'b0, t);
  endtask

  task automatic test_user();
    logic [31:0] d;
    int c0, u0;
    scan(1'b1, 10, 32'h002, d);
    checks += 5;
    if (ir_value !== 10'h002) begin failures++; $display("FAIL user_ir: got %h expected 002", ir_value); end
    c0 = cap_pulses; u0 = upd_pulses;
    cap_data = 8'h3C; cap_valid = 1'b1;
    scan(1'b0, 8, 32'hA5, d);
    cap_valid = 1'b0;
    if (cap_pulses - c0 !== 1) begin failures++; $display("FAIL user_cap_rd: got %0d pulses expected 1", cap_pulses - c0); end
    if (d[7:0] !== 8'h3C) begin failures++; $display("FAIL user_tdo: got %h expected 3c", d[7:0]); end
    if (upd_data !== 8'hA5) begin failures++; $display("FAIL user_upd_data: got %h expected a5", upd_data); end
    if (upd_pulses - u0 !== 1) begin failures++; $display("FAIL user_upd_valid: got %0d pulses expected 1", upd_pulses - u0); end
  endtask

  task automatic test_bypass();
    logic [31:0] d;
    int u0;
    scan(1'b1, 10, 32'h3FF, d);
    checks += 3;
    if (ir_value !== 10'h3FF) begin failures++; $display("FAIL bypass_ir: got %h expected 3ff", ir_value); end
    u0 = upd_pulses;
    scan(1'b0, 4, 32'hD, d);
    if (d[3:0] !== 4'hA) begin failures++; $display("FAIL bypass_tdo: got %h expected a", d[3:0]); end
    if (upd_pulses - u0 !== 0) begin failures++; $display("FAIL bypass_upd_valid: got %0d pulses expected 0", upd_pulses - u0); end
  endtask

  task automatic test_user_nocap();
    logic [31:0] d;
    int c0;
    scan(1'b1, 10, 32'h002, d);
    c0 = cap_pulses;
    cap_data = 8'h77; cap_valid = 1'b0;
    scan(1'b0, 8, 32'hFF, d);
    checks += 4;
    if (cap_pulses - c0 !== 0) begin failures++; $display("FAIL nocap_cap_rd: got %0d pulses expected 0", cap_pulses - c0); end
    if (d[7:0] !== 8'h00) begin failures++; $display("FAIL nocap_tdo: got %h expected 00", d[7:0]); end
    if (upd_data !== 8'hFF) begin failures++; $display("FAIL nocap_upd_data: got %h expected ff", upd_data); end
    scan(1'b1, 10, 32'h002, d);
    if (d[9:0] !== 10'h001) begin failures++; $display("FAIL ir_capture: got %h expected 001", d[9:0]); end
  endtask

  task automatic test_reset_midscan();
    logic t;
    logic [31:0] d;
    int u0;
    u0 = upd_pulses;
    cap_data = 8'hFF; cap_valid = 1'b1;
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1, t);
    cap_valid = 1'b0;
    tms = 1'b0; tdi = 1'b1;
    repeat (5) @(negedge clk);
    tck = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (tap_state !== 4'd0) begin failures++; $display("FAIL midrst_state: got %0d expected 0", tap_state); end
    if (tdo !== 1'b0) begin failures++; $display("FAIL midrst_tdo: got %b expected 0", tdo); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    if (tap_state !== 4'd0) begin failures++; $display("FAIL midrst_no_rise: got %0d expected 0", tap_state); end
    tck = 1'b0;
    repeat (6) @(negedge clk);
    if (upd_pulses - u0 !== 0) begin failures++; $display("FAIL midrst_upd_valid: got %0d pulses expected 0", upd_pulses - u0); end
    tck_cycle(1'b0, 1'b0, t);
    scan(1'b0, 32, 32'h0, d);
    if (d !== 32'h1234_5A5B) begin failures++; $display("FAIL midrst_idcode: got %h expected 12345a5b", d); end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_tlr_return();
    test_user();
    test_bypass();
    test_user_nocap();
    test_reset_midscan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_tap_target.md
# jtag_tap_target

Clock-domain JTAG target (TAP responder) for the far end of the board-level JTAG link driven by the team's JTAG master. It oversamples `tck`/`tms`/`tdi` with `clk` and runs the full 16-state IEEE 1149.1 TAP controller. It implements IR, BYPASS, IDCODE and an 8-bit USER data register, and drives `tdo`. The USER register exchanges bytes with local logic through a capture/update handshake.

## Interface
- `IR_WIDTH`, 10, instruction register width (≥2)
- `DR_WIDTH`, 8, USER data register width
- `IDCODE_VAL`, 32'h1234_5A5B, IDCODE register contents (bit 0 must be 1)
- `IDCODE_INSTR`, 10'h001, opcode selecting IDCODE; IR reset value
- `USER_INSTR`, 10'h002, opcode selecting USER
- all-ones opcode and any undefined opcode select BYPASS
- `clk` in 1 system clock
- `rst` in 1 reset, synchronous, active-high
- `tck` in 1 JTAG clock, asynchronous to `clk`
- `tms` in 1 JTAG mode select
- `tdi` in 1 JTAG serial data in
- `tdo` out 1 JTAG serial data out
- `cap_data` in DR_WIDTH byte loaded into USER at Capture-DR
- `cap_valid` in 1 `cap_data` valid
- `cap_rd` out 1 one-clk pulse: `cap_data` consumed
- `upd_data` out DR_WIDTH last USER value written at Update-DR
- `upd_valid` out 1 one-clk pulse: `upd_data` new
- `ir_value` out IR_WIDTH current active instruction
- `tap_state` out 4 current TAP state code

## Operation
- `tck`, `tms` and `tdi` each pass through a 2-FF synchronizer. `tck` edges are detected from the synchronized value:
  - rise = prev 0, now 1
  - fall = prev 1, now 0
- State codes:
  - TLR 0, RTI 1, SEL_DR 2, CAP_DR 3, SH_DR 4, EX1_DR 5, PA_DR 6, EX2_DR 7, UPD_DR 8
  - SEL_IR 9, CAP_IR 10, SH_IR 11, EX1_IR 12, PA_IR 13, EX2_IR 14, UPD_IR 15
- Transitions on rise, sampling synced `tms` (tms=0 target / tms=1 target):
  - TLR: RTI/TLR
  - RTI: RTI/SEL_DR
  - SEL_DR: CAP_DR/SEL_IR
  - CAP_DR: SH_DR/EX1_DR
  - SH_DR: SH_DR/EX1_DR
  - EX1_DR: PA_DR/UPD_DR
  - PA_DR: PA_DR/EX2_DR
  - EX2_DR: SH_DR/UPD_DR
  - UPD_DR: RTI/SEL_DR
  - SEL_IR: CAP_IR/TLR
  - IR side mirrors DR side; UPD_IR: RTI/SEL_DR
- Register actions on rise, evaluated in the current (pre-transition) state:
  - CAP_IR: IR shift ← {0…0,2'b01}.
  - SH_IR: IR shift ← {tdi, shift[IR_WIDTH-1:1]}.
  - CAP_DR with IDCODE: 32-bit shift ← IDCODE_VAL.
  - CAP_DR with BYPASS: bypass ← 0.
  - CAP_DR with USER: shift ← `cap_valid` ? `cap_data` : 0. `cap_rd` pulses only if `cap_valid`.
  - SH_DR: the selected register shifts right, taking `tdi` at its MSB.
- Actions on fall:
  - In UPD_IR: `ir_value` ← IR shift.
  - In UPD_DR with USER: `upd_data` ← USER shift; `upd_valid` pulses.
  - In SH_IR/SH_DR: `tdo` ← LSB of the selected shift register.
  - In any other state: `tdo` ← 0.
- In TLR, `ir_value` is forced to IDCODE_INSTR every clk.
- Five consecutive rises with `tms`=1 reach TLR from any state.

## Timing
- Reset values:
  - `tap_state`=0 (TLR)
  - `ir_value`=IDCODE_INSTR
  - `tdo`=0
  - `cap_rd`=0
  - `upd_valid`=0
  - `upd_data`=0
  - all shift registers 0
- `rst` mid-operation aborts any shift and returns all of the above immediately. The edge-detect history is also reset, so a `tck` that is high at reset release does not produce a rise.
- `tck` high and low phases must each be ≥4 `clk` periods. `tms`/`tdi` must be stable from 3 clk before the `tck` rise to 3 clk after it. Shorter phases are unsupported.
- Latency from the `tck` pin edge to the resulting action is 3 clk: 2 synchronizer stages plus 1 registered action.
- `tdo` changes 3 clk after the pin's `tck` fall. It is valid well before the next rise, where the master samples it.
- `cap_rd` and `upd_valid` are high for exactly 1 clk per qualifying edge.
- The first bit out of SH_DR is the captured LSB. Bit n appears after the n-th shift rise.

## Test plan
- Reset, then `tms` 0,1,0,0 and 32 shift rises with the final rise at `tms`=1 → `tdo` bits LSB-first equal 32'h1234_5A5B.
- From SH_DR, five rises with `tms`=1 → `tap_state` 0, `ir_value` 10'h001.
- IR scan of 10'h002, then DR scan of `tdi` byte 8'hA5 with `cap_data`=8'h3C and `cap_valid`=1:
  - `cap_rd` pulses once.
  - `tdo` shifts out 0x3C.
  - `upd_data`=8'hA5 with a single `upd_valid` pulse.
- IR=all-ones (BYPASS), DR scan of `tdi` 1,0,1,1 → `tdo` 0,1,0,1 (one-bit delay, leading 0).
- USER capture with `cap_valid`=0 → no `cap_rd` pulse, `tdo` all zeros. An IR scan returns 0…01 on `tdo`.
- `rst` asserted at the 4th shift rise of a USER scan → `tap_state` 0, `tdo` 0, no `upd_valid` pulse. A subsequent IDCODE read is correct.
